timer_counter: RTL and testbench

- Counting core of the 8-bit timer. It sits directly downstream of the APB register block (TDR at 0x00, TCR at 0x01, TSR at 0x02).
- Consumes the TDR value and the TCR control fields. Produces the live count value.
- Also produces single-cycle overflow/underflow pulses, which the status register latches into TSR.
- Contains the clock prescaler, the load logic and the up/down counter.

---
 rtl/timer_counter.sv | 84 ++++++++
 tb/tb_timer_counter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: counting core of the 8-bit timer (prescaler, load, up/down counter).
// Optional one-shot mode is built only when TIMER_ONESHOT_EN is defined.
module timer_counter #(
    parameter int CNT_W = 8,
    parameter int DIV_W = 4
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       cks,
    input  logic             load,
    input  logic [CNT_W-1:0] tdr,
`ifdef TIMER_ONESHOT_EN
    input  logic             oneshot,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             ovf_pulse,
    output logic             udf_pulse
);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] mask;
    logic             tick;
    logic             done;
    logic             at_max;
    logic             at_min;
    logic             wrap;

    // cks selects divide-by 2/4/8/16; the mask keeps the low cks+1 bits
    assign mask   = DIV_W'((32'd2 << cks) - 32'd1);
    assign tick   = en & ~load & ~done & ((div_cnt & mask) == mask);
    assign at_max = (cnt == {CNT_W{1'b1}});
    assign at_min = (cnt == {CNT_W{1'b0}});
    assign wrap   = tick & (up_dn ? at_min : at_max);

    // Prescaler runs only while enabled and not loading; any stop restarts the period
    always_ff @(posedge pclk) begin
        if (preset) begin
            div_cnt <= '0;
        end else if (!en || load) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Counter with load priority and single-cycle wrap pulses
    always_ff @(posedge pclk) begin
        if (preset) begin
            cnt       <= '0;
            ovf_pulse <= 1'b0;
            udf_pulse <= 1'b0;
        end else begin
            ovf_pulse <= 1'b0;
            udf_pulse <= 1'b0;
            if (load) begin
                cnt <= tdr;
            end else if (tick && !up_dn) begin
                cnt       <= cnt + 1'b1;
                ovf_pulse <= at_max;
            end else if (tick && up_dn) begin
                cnt       <= cnt - 1'b1;
                udf_pulse <= at_min;
            end
        end
    end

`ifdef TIMER_ONESHOT_EN
    // Done flag freezes the counter after the first wrap in one-shot mode
    always_ff @(posedge pclk) begin
        if (preset) begin
            done <= 1'b0;
        end else if (load || !en) begin
            done <= 1'b0;
        end else if (wrap && oneshot) begin
            done <= 1'b1;
        end
    end
`else
    assign done = 1'b0;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: scoreboard bench for timer_counter.
// Build with TIMER_ONESHOT_EN defined to also exercise one-shot mode.
module tb_timer_counter;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic [1:0] cks = 2'd0;
    logic       load = 1'b0;
    logic [7:0] tdr = 8'h00;
    logic       oneshot = 1'b0;
    logic [7:0] cnt;
    logic       ovf_pulse;
    logic       udf_pulse;

    int errors = 0;
    int checks = 0;
    int ovf_seen = 0;
    int udf_seen = 0;

    typedef struct {
        logic [7:0] c;
        logic       o;
        logic       u;
    } exp_t;

    exp_t sb[$];

    logic [7:0] md_cnt = 8'h00;
    int         md_div = 0;
    bit         md_done = 1'b0;
    bit         md_ovf = 1'b0;
    bit         md_udf = 1'b0;

    timer_counter dut (
        .pclk      (pclk),
        .preset    (preset),
        .en        (en),
        .up_dn     (up_dn),
        .cks       (cks),
        .load      (load),
        .tdr       (tdr),
`ifdef TIMER_ONESHOT_EN
        .oneshot   (oneshot),
`endif
        .cnt       (cnt),
        .ovf_pulse (ovf_pulse),
        .udf_pulse (udf_pulse)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one clock edge worth of behaviour
    task automatic model_edge();
        int  per;
        bit  tick;
        bit  os;
        per = 2 ** (int'(cks) + 1);
`ifdef TIMER_ONESHOT_EN
        os = oneshot;
`else
        os = 1'b0;
`endif
        if (preset) begin
            md_cnt = 8'h00;
            md_div = 0;
            md_done = 1'b0;
            md_ovf = 1'b0;
            md_udf = 1'b0;
            return;
        end
        md_ovf = 1'b0;
        md_udf = 1'b0;
        tick = en && !load && !md_done && ((md_div % per) == per - 1);
        if (load) begin
            md_cnt = tdr;
        end else if (tick) begin
            if (!up_dn) begin
                if (md_cnt == 8'hFF) begin
                    md_cnt = 8'h00;
                    md_ovf = 1'b1;
                    if (os) md_done = 1'b1;
                end else begin
                    md_cnt = md_cnt + 8'd1;
                end
            end else begin
                if (md_cnt == 8'h00) begin
                    md_cnt = 8'hFF;
                    md_udf = 1'b1;
                    if (os) md_done = 1'b1;
                end else begin
                    md_cnt = md_cnt - 8'd1;
                end
            end
        end
        if (load || !en) md_done = 1'b0;
        md_div = (en && !load) ? (md_div + 1) % 16 : 0;
    endtask

    task automatic step();
        exp_t e;
        exp_t g;
        model_edge();
        e.c = md_cnt;
        e.o = md_ovf;
        e.u = md_udf;
        sb.push_back(e);
        @(posedge pclk);
        #1;
        g = sb.pop_front();
        chk("cnt", 32'(cnt), 32'(g.c));
        chk("ovf", 32'(ovf_pulse), 32'(g.o));
        chk("udf", 32'(udf_pulse), 32'(g.u));
        chk("excl", 32'(ovf_pulse & udf_pulse), 32'd0);
        if (ovf_pulse) ovf_seen++;
        if (udf_pulse) udf_seen++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset dominates load and enable
        preset = 1'b1; en = 1'b1; tdr = 8'hA5; load = 1'b1;
        steps(2);
        preset = 1'b0; load = 1'b0; en = 1'b0;
        step();
        chk("rst_cnt", 32'(cnt), 32'h00);
        chk("rst_ovf", 32'(ovf_pulse), 32'd0);
        chk("rst_udf", 32'(udf_pulse), 32'd0);

        // Load and divide-by-2 stepping
        en = 1'b1; up_dn = 1'b0; cks = 2'd0; tdr = 8'h10; load = 1'b1;
        step();
        chk("load10", 32'(cnt), 32'h10);
        load = 1'b0;
        steps(2);
        chk("inc11", 32'(cnt), 32'h11);
        steps(2);
        chk("inc12", 32'(cnt), 32'h12);

        // Divide-by-16 after a reload
        cks = 2'd3; tdr = 8'h20; load = 1'b1;
        step();
        load = 1'b0;
        steps(15);
        chk("d16_hold", 32'(cnt), 32'h20);
        step();
        chk("d16_inc", 32'(cnt), 32'h21);
        steps(16);
        chk("d16_inc2", 32'(cnt), 32'h22);

        // Overflow
        cks = 2'd0; tdr = 8'hFE; load = 1'b1;
        step();
        load = 1'b0; ovf_seen = 0; udf_seen = 0;
        steps(4);
        chk("ovf_cnt", 32'(cnt), 32'h00);
        chk("ovf_once", 32'(ovf_seen), 32'd1);
        chk("ovf_noudf", 32'(udf_seen), 32'd0);

        // Underflow at divide-by-4
        up_dn = 1'b1; cks = 2'd1; tdr = 8'h01; load = 1'b1;
        step();
        load = 1'b0; ovf_seen = 0; udf_seen = 0;
        steps(8);
        chk("udf_cnt", 32'(cnt), 32'hFF);
        chk("udf_once", 32'(udf_seen), 32'd1);
        chk("udf_noovf", 32'(ovf_seen), 32'd0);

        // Load on the tick cycle wins
        up_dn = 1'b0; cks = 2'd0; tdr = 8'h40; load = 1'b1;
        step();
        load = 1'b0;
        step();
        tdr = 8'h55; load = 1'b1;
        step();
        chk("load_wins", 32'(cnt), 32'h55);
        load = 1'b0;

        // Enable drop mid-period, then full period on restart
        cks = 2'd2;
        steps(5);
        en = 1'b0;
        steps(3);
        chk("frozen", 32'(cnt), 32'h55);
        en = 1'b1;
        steps(7);
        chk("restart_hold", 32'(cnt), 32'h55);
        step();
        chk("restart_inc", 32'(cnt), 32'h56);

        // Direction change mid-count
        cks = 2'd0;
        steps(3);
        up_dn = 1'b1;
        steps(6);

`ifdef TIMER_ONESHOT_EN
        oneshot = 1'b1; up_dn = 1'b0; cks = 2'd0; tdr = 8'hFF; load = 1'b1;
        step();
        load = 1'b0; ovf_seen = 0;
        steps(100);
        chk("os_once", 32'(ovf_seen), 32'd1);
        chk("os_hold", 32'(cnt), 32'h00);
        load = 1'b1;
        step();
        load = 1'b0;
        steps(4);
        chk("os_rearm", 32'(ovf_seen), 32'd2);
        oneshot = 1'b0;
`endif

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            preset = ($urandom_range(0, 40) == 0);
            en     = ($urandom_range(0, 7) != 0);
            up_dn  = ($urandom_range(0, 15) == 0) ? ~up_dn : up_dn;
            cks    = ($urandom_range(0, 31) == 0) ? 2'($urandom_range(0, 3)) : cks;
            load   = ($urandom_range(0, 19) == 0);
            tdr    = ($urandom_range(0, 1) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
`ifdef TIMER_ONESHOT_EN
            oneshot = ($urandom_range(0, 1) == 0);
`endif
            step();
        end

        // Reset mid-count beats load
        preset = 1'b1; en = 1'b1; load = 1'b1; tdr = 8'h77;
        step();
        chk("rst_mid", 32'(cnt), 32'h00);
        preset = 1'b0; load = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
